// File: rtl/qpd_requester_pkg.sv
// Shared types and constants for the quarter-period-delay requester.
package qpd_requester_pkg;

    typedef enum logic [1:0] {
        ARM       = 2'd0,
        MEASURE   = 2'd1,
        REQUEST   = 2'd2,
        WAIT_TRIG = 2'd3
    } state_e;

    localparam int unsigned Q_W        = 8;
    localparam int unsigned Q_MAX      = (1 << Q_W) - 1;
    localparam int unsigned MIN_PERIOD = 4;

endpackage

// File: rtl/qpd_requester_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// An input rise becomes a one-cycle pulse three clock edges after it is first sampled.
module sync_edge (
    input  logic sclock,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic meta;
    logic sync;
    logic sync_prev;

    always_ff @(posedge sclock) begin
        if (rst) begin
            meta      <= 1'b0;
            sync      <= 1'b0;
            sync_prev <= 1'b0;
            rise      <= 1'b0;
        end else begin
            meta      <= d;
            sync      <= meta;
            sync_prev <= sync;
            rise      <= sync & ~sync_prev;
        end
    end

endmodule

// File: rtl/qpd_requester.sv
// Measures the period of ref_in, derives a quarter-period count and requests a
// delayed trigger from the delay block whenever that count changes.
module qpd_requester
    import qpd_requester_pkg::*;
#(
    parameter int unsigned PERIOD_BITS    = 10,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic           sclock,
    input  logic           rst,
    input  logic           enable,
    input  logic           ref_in,
    input  logic           trigger,
    output logic           rt,
    output logic [Q_W-1:0] count_quater_period,
    output logic           busy,
    output logic           done,
    output logic           err_short,
    output logic           err_long,
    output logic           err_timeout
);

    localparam int unsigned            TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PERIOD_BITS-1:0] PERIOD_MAX   = '1;
    localparam logic [TW-1:0]          TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_e                 state;
    logic                   ref_rise;
    logic                   trig_rise;
    logic [PERIOD_BITS-1:0] period_cnt;
    logic [TW-1:0]          wait_cnt;
    logic [Q_W-1:0]         last_q;
    logic [PERIOD_BITS-1:0] quarter_full_c;
    logic [Q_W-1:0]         quarter_c;
    logic                   too_short_c;

    sync_edge u_ref_sync (
        .sclock (sclock),
        .rst    (rst),
        .d      (ref_in),
        .rise   (ref_rise)
    );

    sync_edge u_trig_sync (
        .sclock (sclock),
        .rst    (rst),
        .d      (trigger),
        .rise   (trig_rise)
    );

    // Quarter of the running period count, clamped to the output width.
    always_comb begin
        quarter_full_c = period_cnt >> 2;
        quarter_c      = Q_W'(quarter_full_c);
        if (32'(quarter_full_c) > Q_MAX) begin
            quarter_c = '1;
        end
        too_short_c = 32'(period_cnt) < MIN_PERIOD;
    end

    always_ff @(posedge sclock) begin
        if (rst) begin
            state               <= ARM;
            rt                  <= 1'b0;
            done                <= 1'b0;
            busy                <= 1'b0;
            count_quater_period <= '0;
            last_q              <= '0;
            err_short           <= 1'b0;
            err_long            <= 1'b0;
            err_timeout         <= 1'b0;
            period_cnt          <= '0;
            wait_cnt            <= '0;
        end else begin
            rt   <= 1'b0;
            done <= 1'b0;
            if (!enable) begin
                state <= ARM;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ARM: begin
                        if (ref_rise) begin
                            state      <= MEASURE;
                            busy       <= 1'b1;
                            period_cnt <= PERIOD_BITS'(1);
                        end
                    end
                    MEASURE: begin
                        // A closing edge on the saturation cycle still yields a valid period.
                        if (ref_rise) begin
                            state <= ARM;
                            busy  <= 1'b0;
                            if (too_short_c) begin
                                err_short <= 1'b1;
                            end else if (quarter_c != last_q) begin
                                count_quater_period <= quarter_c;
                                state               <= REQUEST;
                                busy                <= 1'b1;
                            end
                        end else if (period_cnt == PERIOD_MAX) begin
                            err_long <= 1'b1;
                            state    <= ARM;
                            busy     <= 1'b0;
                        end else begin
                            period_cnt <= period_cnt + PERIOD_BITS'(1);
                        end
                    end
                    REQUEST: begin
                        rt       <= 1'b1;
                        last_q   <= count_quater_period;
                        wait_cnt <= '0;
                        state    <= WAIT_TRIG;
                    end
                    WAIT_TRIG: begin
                        // Trigger takes priority over a timeout expiring in the same cycle.
                        if (trig_rise) begin
                            done  <= 1'b1;
                            state <= ARM;
                            busy  <= 1'b0;
                        end else if (wait_cnt == TIMEOUT_LAST) begin
                            err_timeout <= 1'b1;
                            state       <= ARM;
                            busy        <= 1'b0;
                        end else begin
                            wait_cnt <= wait_cnt + TW'(1);
                        end
                    end
                    default: begin
                        state <= ARM;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qpd_requester.sv
// Randomized bench for qpd_requester: a transaction-level model predicts when
// each request, done pulse and error should appear for every measured period.
module tb_qpd_requester;

    logic       sclock;
    logic       rst;
    logic       enable;
    logic       ref_in;
    logic       trigger;
    logic       rt;
    logic [7:0] count_quater_period;
    logic       busy;
    logic       done;
    logic       err_short;
    logic       err_long;
    logic       err_timeout;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Event log captured from the outputs
    int rt_n = 0, rt_cyc = 0, rt_q = 0, rt_q_prev = 0;
    int done_n = 0, done_cyc = 0;
    int short_cyc = 0, long_cyc = 0, to_cyc = 0;
    logic [7:0] cqp_prev = '0;
    logic p_short = 1'b0, p_long = 1'b0, p_to = 1'b0;

    // Reference model state
    int m_last = 0, m_cqp = 0;
    bit m_short = 0, m_long = 0, m_to = 0;

    qpd_requester #(
        .PERIOD_BITS    (10),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .sclock              (sclock),
        .rst                 (rst),
        .enable              (enable),
        .ref_in              (ref_in),
        .trigger             (trigger),
        .rt                  (rt),
        .count_quater_period (count_quater_period),
        .busy                (busy),
        .done                (done),
        .err_short           (err_short),
        .err_long            (err_long),
        .err_timeout         (err_timeout)
    );

    initial sclock = 1'b0;
    always #5 sclock = ~sclock;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge sclock);
    endtask

    initial begin
        forever begin
            @(posedge sclock);
            #1;
            cyc++;
            if (rt === 1'b1) begin
                rt_n++;
                rt_cyc    = cyc;
                rt_q      = int'(count_quater_period);
                rt_q_prev = int'(cqp_prev);
            end
            if (done === 1'b1) begin
                done_n++;
                done_cyc = cyc;
            end
            if (err_short === 1'b1 && !p_short) short_cyc = cyc;
            if (err_long === 1'b1 && !p_long) long_cyc = cyc;
            if (err_timeout === 1'b1 && !p_to) to_cyc = cyc;
            p_short  = err_short;
            p_long   = err_long;
            p_to     = err_timeout;
            cqp_prev = count_quater_period;
        end
    end

    task automatic model_reset();
        m_last  = 0;
        m_cqp   = 0;
        m_short = 0;
        m_long  = 0;
        m_to    = 0;
    endtask

    task automatic do_reset();
        wait_until(cyc + 2);
        rst = 1'b1;
        wait_until(cyc + 2);
        rst = 1'b0;
        model_reset();
        wait_until(cyc + 1);
        check("rst_rt", int'(rt), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cqp", int'(count_quater_period), 0);
        check("rst_err_short", int'(err_short), 0);
        check("rst_err_long", int'(err_long), 0);
        check("rst_err_timeout", int'(err_timeout), 0);
    endtask

    // One measurement of period t; the trigger answers d cycles after rt.
    // abort_kind: 0 none, 1 reset 50 cycles into the wait, 2 enable dropped there.
    task automatic run(input int t, input int d, input bit no_trig, input int abort_kind);
        int c0, close_c, rt_c, trig_c, end_c, rt0, done0, q, exp_done_c;
        bit req, exp_done, new_short, new_long, new_to;
        req = 0; exp_done = 0; new_short = 0; new_long = 0; new_to = 0;
        rt_c = 0; q = 0; trig_c = -1; close_c = 0; exp_done_c = 0;
        wait_until(cyc + 8);
        rt0   = rt_n;
        done0 = done_n;
        c0    = cyc;
        ref_in = 1'b1;
        if (t >= 1024) begin
            new_long = !m_long;
            m_long   = 1;
            end_c    = c0 + 1036;
            wait_until(c0 + 1030);
            ref_in = 1'b0;
        end else begin
            wait_until(c0 + ((t / 2 > 0) ? t / 2 : 1));
            ref_in = 1'b0;
            wait_until(c0 + t);
            ref_in = 1'b1;
            wait_until(c0 + t + 1);
            ref_in = 1'b0;
            // Three synchronizer/edge cycles plus one FSM cycle after the drive
            close_c = c0 + t + 4;
            end_c   = close_c + 15;
            if (t < 4) begin
                new_short = !m_short;
                m_short   = 1;
                trig_c    = c0 + t + 10;
            end else begin
                q = (t / 4 > 255) ? 255 : t / 4;
                if (q == m_last) begin
                    trig_c = c0 + t + 10;
                end else begin
                    req    = 1;
                    rt_c   = close_c + 1;
                    m_cqp  = q;
                    m_last = q;
                    if (abort_kind != 0) begin
                        trig_c = rt_c + 60;
                        end_c  = rt_c + 70;
                    end else if (no_trig || d + 4 > 1024) begin
                        new_to = !m_to;
                        m_to   = 1;
                        if (!no_trig) trig_c = rt_c + d;
                        end_c  = rt_c + 1030;
                    end else begin
                        exp_done   = 1;
                        trig_c     = rt_c + d;
                        exp_done_c = rt_c + d + 4;
                        end_c      = exp_done_c + 6;
                    end
                end
            end
            if (req && abort_kind != 0) begin
                wait_until(rt_c + 50);
                if (abort_kind == 1) begin
                    rst = 1'b1;
                    wait_until(rt_c + 51);
                    rst = 1'b0;
                    model_reset();
                end else begin
                    enable = 1'b0;
                    wait_until(rt_c + 51);
                    enable = 1'b1;
                end
            end
            if (trig_c >= 0) begin
                wait_until(trig_c);
                trigger = 1'b1;
                wait_until(trig_c + 2);
                trigger = 1'b0;
            end
        end
        wait_until(end_c);

        check("rt_count", rt_n - rt0, int'(req));
        if (req) begin
            check("rt_cycle", rt_cyc, rt_c);
            check("cqp_at_rt", rt_q, q);
            check("cqp_before_rt", rt_q_prev, q);
        end
        check("done_count", done_n - done0, int'(exp_done));
        if (exp_done) check("done_cycle", done_cyc, exp_done_c);
        if (new_short) check("short_cycle", short_cyc, close_c);
        if (new_long) check("long_cycle", long_cyc, c0 + 1027);
        if (new_to) check("timeout_cycle", to_cyc, rt_c + 1024);
        check("err_short", int'(err_short), int'(m_short));
        check("err_long", int'(err_long), int'(m_long));
        check("err_timeout", int'(err_timeout), int'(m_to));
        check("cqp_held", int'(count_quater_period), m_cqp);
        check("busy_idle", int'(busy), 0);
    endtask

    initial begin
        int k, d;
        rst     = 1'b1;
        enable  = 1'b1;
        ref_in  = 1'b0;
        trigger = 1'b0;
        do_reset();

        run(400, 100, 0, 0);   // basic request, Q=100
        run(400, 20, 0, 0);    // unchanged Q: no request, stray trigger ignored
        run(3, 0, 0, 0);       // too short
        do_reset();
        run(2000, 0, 0, 0);    // static reference
        do_reset();
        run(400, 0, 1, 0);     // no trigger returned
        do_reset();
        run(400, 1020, 0, 0);  // trigger lands on the timeout cycle
        run(404, 1021, 0, 0);  // trigger one cycle too late
        do_reset();
        run(400, 0, 0, 1);     // reset while waiting
        run(1023, 5, 0, 0);    // largest period, Q=255
        run(800, 0, 0, 2);     // enable dropped while waiting
        run(801, 3, 0, 0);     // same Q as the aborted request

        for (int i = 0; i < 20; i++) begin
            k = int'($urandom_range(0, 9));
            d = int'($urandom_range(0, 60));
            if (k == 0) begin
                run(int'($urandom_range(2, 3)), 0, 0, 0);
                do_reset();
            end else if (k == 1 && m_last > 0) begin
                run(m_last * 4 + int'($urandom_range(0, 3)), d, 0, 0);
            end else if (k == 2) begin
                run(int'($urandom_range(4, 700)), d, 0, 2);
            end else begin
                run(int'($urandom_range(4, 700)), d, 0, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/qpd_requester.md
QPD_REQUESTER -- requirements
Module: qpd_requester

Interface
REQ-001 Parameter PERIOD_BITS, default 10, width of period counter (cycles of sclock).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, maximum wait for trigger after a request.
REQ-003 sclock  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  high = run measurement/request cycle; low = hold in ARM.
REQ-006 ref_in  input  1  asynchronous reference square wave whose period is measured.
REQ-007 trigger  input  1  trigger returned by the quarter-period-delay block.
REQ-008 rt  output  1  one-cycle request strobe to the delay block.
REQ-009 count_quater_period  output  8  quarter-period count presented to the delay block.
REQ-010 busy  output  1  high in any state other than ARM.
REQ-011 done  output  1  one-cycle pulse when a requested trigger is received.
REQ-012 err_short  output  1  sticky; measured period below 4 cycles.
REQ-013 err_long  output  1  sticky; no closing edge before period counter saturates.
REQ-014 err_timeout  output  1  sticky; no trigger within TIMEOUT_CYCLES.

Function
REQ-015 ref_in SHALL pass a 2-flop synchronizer; rising edge = synced high and previous synced low; edge detect adds 3 cycles latency.
REQ-016 FSM states SHALL be ARM, MEASURE, REQUEST, WAIT_TRIG.
REQ-017 ARM: on rising edge with enable high -> MEASURE, period counter cleared to 1.
REQ-018 MEASURE: counter +1 per cycle; on next rising edge, P = counter value at that cycle.
REQ-019 MEASURE: P < 4 -> set err_short, -> ARM; counter reaching 2^PERIOD_BITS-1 without edge -> set err_long, -> ARM.
REQ-020 Quarter value Q = P >> 2, saturated to 255 if wider than 8 bits.
REQ-021 Q equal to last issued Q -> no request, -> ARM; otherwise count_quater_period <= Q and -> REQUEST.
REQ-022 count_quater_period SHALL be stable at least one cycle before rt rises and held until the next issued value.
REQ-023 REQUEST: rt high exactly one cycle, last issued Q updated, timeout counter cleared, -> WAIT_TRIG.
REQ-024 WAIT_TRIG: rising edge of trigger -> done pulse one cycle, -> ARM.
REQ-025 WAIT_TRIG: timeout counter reaches TIMEOUT_CYCLES -> set err_timeout, -> ARM.
REQ-026 Trigger edge and timeout in same cycle: trigger wins, no error.
REQ-027 enable low in any state: -> ARM next cycle, no rt, no done; count_quater_period and error flags held.
REQ-028 Trigger edges outside WAIT_TRIG SHALL be ignored.

Reset
REQ-029 rst SHALL force ARM, rt=0, done=0, busy=0, count_quater_period=0, last issued Q=0, all error flags=0, synchronizer flops=0.
REQ-030 rst mid-MEASURE or mid-WAIT_TRIG SHALL abort without rt or done pulse.
REQ-031 First post-reset measurement with Q=0 SHALL NOT issue a request (matches last issued Q=0).

Structure
REQ-032 Shared package SHALL hold FSM state enum, quarter-count width (8), and minimum period constant (4).
REQ-033 The synchronizer plus rising-edge detector SHALL be a sub-module, sync_edge, instanced twice (ref_in, trigger).

Verification
REQ-034 ref_in period 400 cycles, trigger returned 100 cycles after rt -> count_quater_period=100, one rt pulse, done pulse, no errors.
REQ-035 Two consecutive periods of 400 cycles -> second measurement issues no rt.
REQ-036 ref_in period 3 cycles -> err_short=1, rt never asserted; ref_in static -> err_long=1 after 1023 cycles.
REQ-037 Period 400, trigger never returned -> err_timeout=1 exactly 1024 cycles after rt, FSM in ARM.
REQ-038 rst asserted 50 cycles into WAIT_TRIG, trigger then arrives -> no done, all outputs at reset values.
REQ-039 Trigger edge coincident with timeout cycle -> done=1, err_timeout=0.
